serv_rf_ram_resp: RTL and testbench
===================================

Name: serv_rf_ram_resp

Overview:
- RAM-side responder for the bit-serial register-file SRAM interface: it consumes the write/read address, data and enable signals driven by the core-side RAM interface and returns read data.
- Implements the 1R1W register-file storage with exactly one cycle of read latency.
- Clears storage to zero after reset.
- Provides a handshaked debug/host access port that uses RAM cycles the core leaves idle.

Parameters:
- width, 8, RAM data width; power of two, 2..32.
- csr_regs, 0, CSR registers stored after the GPRs.
- rf_count, 32, number of GPRs.
- depth, (rf_count+csr_regs)*32/width, number of RAM words (derived; do not override).
- aw, $clog2(depth), RAM address width (derived; 7 for the defaults).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_waddr  in  aw  core write address
- i_wdata  in  width  core write data
- i_wen  in  1  core write enable
- i_raddr  in  aw  core read address
- i_ren  in  1  core read enable
- o_rdata  out  width  core read data, registered
- o_init_done  out  1  storage cleared; top level holds the core in reset until this is 1
- i_dbg_req  in  1  debug request; held until o_dbg_ack
- i_dbg_we  in  1  debug write (1) / read (0)
- i_dbg_addr  in  aw  debug word address
- i_dbg_wdata  in  width  debug write data
- o_dbg_ack  out  1  single-cycle completion pulse
- o_dbg_rdata  out  width  debug read data

Behaviour:
- Reset values: o_rdata=0, o_init_done=0, o_dbg_ack=0, o_dbg_rdata=0. RAM contents are not reset directly; they are cleared by the CLEAR FSM.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR with clr_cnt=0.
  - In CLEAR: word clr_cnt is written with 0 each cycle; clr_cnt increments.
  - After word depth-1 is written, transition to RUN. o_init_done=1 from the following cycle, i.e. the depth-th cycle after reset deasserts.
  - Reset asserted mid-CLEAR restarts from word 0.
- In CLEAR, i_wen, i_ren and i_dbg_req are ignored; no ack is issued.
- Core write (RUN): if i_wen=1, mem[i_waddr]<=i_wdata at the clock edge.
- Core read (RUN): if i_ren=1, o_rdata<=mem[i_raddr] at the clock edge; data is visible the following cycle. If i_ren=0, o_rdata holds its value.
- Read-during-write to the same address in the same cycle is read-first: the old data is returned.
- Debug grant is evaluated each RUN cycle when i_dbg_req=1 and o_dbg_ack=0:
  - Read (we=0) is granted only if i_ren=0. At the edge, o_dbg_rdata<=mem[i_dbg_addr].
  - Write (we=1) is granted only if i_wen=0. At the edge, mem[i_dbg_addr]<=i_dbg_wdata.
  - Grant in cycle T gives o_dbg_ack=1 in cycle T+1 only. Read data is valid in T+1 and held until the next debug read.
  - No grant is made in a cycle where o_dbg_ack=1, so a requester still holding req during the ack cycle is not serviced twice.
  - The core always has priority. A debug request starves while the core keeps the needed port busy; there is no timeout.
- Debug read/write to the same address as a simultaneous core write (the debug read is allowed when i_ren=0) is read-first: it returns the old data.
- o_dbg_rdata is unaffected by core reads; o_rdata is unaffected by debug reads.
- Addresses >= depth (non-power-of-two depth) are don't-care: no write occurs and the read value is unspecified.

Optional Feature:
- Macro SERV_RF_RAM_RESP_CLEAR_EN.
- Defined: the CLEAR state and clr_cnt exist as described above.
- Undefined: reset enters RUN directly, o_init_done=1 in the first cycle after reset deasserts, and RAM contents after power-up are undefined (X in simulation).

Test Plan:
- Clear timing (CLEAR_EN, defaults): release reset → o_init_done rises in the 128th cycle after release; a subsequent read of every address returns 0x00.
- Core write/read latency: write i_waddr=0x05, i_wdata=0xA5; next cycle i_ren=1, i_raddr=0x05 → o_rdata=0xA5 one cycle later; o_rdata holds 0xA5 while i_ren=0.
- Read-first collision: mem[0x10]=0x11; same cycle i_wen=1 (0x10, 0x22) and i_ren=1 (0x10) → o_rdata=0x11; next read returns 0x22.
- Debug starvation then grant: i_dbg_req=1, we=0, addr=0x05 with i_ren=1 for 10 cycles → no ack. Drop i_ren → o_dbg_ack pulses exactly once one cycle later with o_dbg_rdata=0xA5, even though req stays high during the ack cycle.
- Debug write vs core read: debug write 0x3C to 0x7F while i_ren=1 and i_wen=0 → granted immediately, ack next cycle; a core read of 0x7F then returns 0x3C.
- Reset mid-clear: assert i_rst at clr_cnt=50 → o_init_done stays 0 and the full 128-cycle clear restarts. Without the macro → o_init_done=1 one cycle after reset release.

Source files
------------

// File: rtl/serv_rf_ram_resp.sv
// serv_rf_ram_resp
//
// RAM-side responder for the bit-serial register-file SRAM interface.
// Holds the 1R1W register-file storage, returns core read data with one
// cycle of latency, and offers a handshaked debug/host port that borrows
// RAM cycles the core leaves idle. The core always has priority.
//
// Optional feature, macro SERV_RF_RAM_RESP_CLEAR_EN:
//   defined   - after reset every word is written with zero, one per cycle,
//               before o_init_done rises (depth cycles after reset release).
//   undefined - no clear pass; o_init_done rises one cycle after reset
//               release and RAM contents start undefined.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_waddr/i_wdata/i_wen   core write port
//   i_raddr/i_ren           core read port
//   o_rdata                 core read data, registered (held when i_ren=0)
//   o_init_done             storage ready; core held in reset until set
//   i_dbg_req/i_dbg_we      debug request (held until ack) and direction
//   i_dbg_addr/i_dbg_wdata  debug word address and write data
//   o_dbg_ack               one-cycle completion pulse
//   o_dbg_rdata             debug read data, held until the next debug read
module serv_rf_ram_resp #(
    parameter int width    = 8,
    parameter int csr_regs = 0,
    parameter int rf_count = 32,
    localparam int depth   = (rf_count + csr_regs) * 32 / width,
    localparam int aw      = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [aw-1:0]    i_dbg_addr,
    input  logic [width-1:0] i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [width-1:0] o_dbg_rdata
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Depth widened by one bit so it is representable even when depth is a
    // power of two; used to drop writes to addresses outside the array.
    localparam logic [aw:0] DEPTH_W = (aw+1)'(depth);

    logic [width-1:0] mem [0:depth-1];

    state_t           state_q, state_d;
    logic             init_done_q, init_done_d;
    logic             dbg_ack_q, dbg_ack_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic [width-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
    localparam logic [aw-1:0] LAST_WORD = aw'(depth - 1);
    logic [aw-1:0]    clr_cnt_q, clr_cnt_d;
`endif

    // Single shared write port: clear pass, core write, or debug write.
    // Core and debug writes never coincide since a debug write is only
    // granted while the core write port is idle.
    logic             mem_we;
    logic [aw-1:0]    mem_waddr;
    logic [width-1:0] mem_wdata;
    logic             dbg_grant;

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_grant   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = i_waddr;
        mem_wdata   = i_wdata;
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            CLEAR: begin
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_WORD)
                    state_d = RUN;
`else
                state_d = RUN;
`endif
            end
            default: begin
                if (i_ren)
                    rdata_d = mem[i_raddr];
                // No grant during the ack cycle, so a requester still holding
                // req while it sees the ack is not serviced a second time.
                if (i_dbg_req && !dbg_ack_q)
                    dbg_grant = i_dbg_we ? !i_wen : !i_ren;
                if (i_wen) begin
                    mem_we = 1'b1;
                end else if (dbg_grant && i_dbg_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = i_dbg_addr;
                    mem_wdata = i_dbg_wdata;
                end
                if (dbg_grant && !i_dbg_we)
                    dbg_rdata_d = mem[i_dbg_addr];
            end
        endcase
        init_done_d = (state_d == RUN);
        dbg_ack_d   = dbg_grant;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
`else
            state_q   <= RUN;
`endif
            init_done_q <= 1'b0;
            dbg_ack_q   <= 1'b0;
            rdata_q     <= '0;
            dbg_rdata_q <= '0;
        end else begin
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
            state_q     <= state_d;
            init_done_q <= init_done_d;
            dbg_ack_q   <= dbg_ack_d;
            rdata_q     <= rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Reads above sample mem before this update, giving read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (mem_we && ({1'b0, mem_waddr} < DEPTH_W))
            mem[mem_waddr] <= mem_wdata;
    end

    assign o_rdata     = rdata_q;
    assign o_init_done = init_done_q;
    assign o_dbg_ack   = dbg_ack_q;
    assign o_dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// Directed bench for serv_rf_ram_resp with default parameters
// (width=8, depth=128, aw=7). Expectations adapt to
// SERV_RF_RAM_RESP_CLEAR_EN being defined or not.
module tb_serv_rf_ram_resp;

    localparam int W  = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] waddr, raddr, dbg_addr;
    logic [W-1:0]  wdata, dbg_wdata;
    logic          wen, ren, dbg_req, dbg_we;
    logic [W-1:0]  rdata, dbg_rdata;
    logic          init_done, dbg_ack;

    int n_tests = 0;
    int n_fail  = 0;

    serv_rf_ram_resp dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_raddr     (raddr),
        .i_ren       (ren),
        .o_rdata     (rdata),
        .o_init_done (init_done),
        .i_dbg_req   (dbg_req),
        .i_dbg_we    (dbg_we),
        .i_dbg_addr  (dbg_addr),
        .i_dbg_wdata (dbg_wdata),
        .o_dbg_ack   (dbg_ack),
        .o_dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_read(input logic [AW-1:0] a);
        ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        waddr = '0; wdata = '0; wen = 1'b0;
        raddr = '0; ren = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) tick();

        chk("rst_rdata",     32'(rdata),     32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_dbg_ack",   32'(dbg_ack),   32'h0);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);

        rst = 1'b0;
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
        // Core and debug traffic during the clear pass must be ignored.
        wen = 1'b1; waddr = 7'h03; wdata = 8'hFF;
        ren = 1'b1; raddr = 7'h03;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h03;
        bad = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (dbg_ack !== 1'b0) bad++;
        end
        chk("clear_no_ack", 32'(bad), 32'h0);
        chk("clear_init_127", 32'(init_done), 32'h0);
        chk("clear_rdata_held", 32'(rdata), 32'h0);
        wen = 1'b0; ren = 1'b0; dbg_req = 1'b0;
        tick();
        chk("clear_init_128", 32'(init_done), 32'h1);
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            core_read(AW'(a));
            if (rdata !== 8'h00) bad++;
        end
        chk("clear_all_zero", 32'(bad), 32'h0);
`else
        tick();
        chk("init_1cyc", 32'(init_done), 32'h1);
`endif

        // Core write then read: one cycle latency, held while ren=0.
        core_write(7'h05, 8'hA5);
        core_read(7'h05);
        chk("rd_latency", 32'(rdata), 32'hA5);
        tick(); tick();
        chk("rd_hold", 32'(rdata), 32'hA5);

        // Read-first on same-address collision.
        core_write(7'h10, 8'h11);
        wen = 1'b1; waddr = 7'h10; wdata = 8'h22;
        ren = 1'b1; raddr = 7'h10;
        tick();
        wen = 1'b0; ren = 1'b0;
        chk("rf_old", 32'(rdata), 32'h11);
        core_read(7'h10);
        chk("rf_new", 32'(rdata), 32'h22);

        // Debug read starves while the core read port is busy.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h05;
        ren = 1'b1; raddr = 7'h10;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dbg_ack !== 1'b0) bad++;
        end
        chk("dbg_starve", 32'(bad), 32'h0);
        ren = 1'b0;
        tick();
        chk("dbg_rd_ack", 32'(dbg_ack), 32'h1);
        chk("dbg_rd_data", 32'(dbg_rdata), 32'hA5);
        chk("core_rd_kept", 32'(rdata), 32'h22);
        tick();  // req still held through the ack cycle
        chk("dbg_ack_once", 32'(dbg_ack), 32'h0);
        dbg_req = 1'b0;
        tick();
        chk("dbg_ack_idle", 32'(dbg_ack), 32'h0);

        // Debug write granted while the core only reads.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h7F; dbg_wdata = 8'h3C;
        ren = 1'b1; raddr = 7'h05;
        tick();
        dbg_req = 1'b0; ren = 1'b0;
        chk("dbg_wr_ack", 32'(dbg_ack), 32'h1);
        chk("dbg_wr_core_rd", 32'(rdata), 32'hA5);
        core_read(7'h7F);
        chk("dbg_wr_data", 32'(rdata), 32'h3C);
        chk("dbg_rdata_kept", 32'(dbg_rdata), 32'hA5);

        // Debug write blocked by core writes.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h20; dbg_wdata = 8'h77;
        wen = 1'b1; waddr = 7'h21; wdata = 8'h55;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dbg_ack !== 1'b0) bad++;
        end
        chk("dbg_wr_starve", 32'(bad), 32'h0);
        wen = 1'b0;
        tick();
        dbg_req = 1'b0;
        chk("dbg_wr_ack2", 32'(dbg_ack), 32'h1);
        core_read(7'h20);
        chk("dbg_wr_mem20", 32'(rdata), 32'h77);
        core_read(7'h21);
        chk("core_wr_mem21", 32'(rdata), 32'h55);

        // Debug read racing a core write to the same word: read-first.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h21;
        wen = 1'b1; waddr = 7'h21; wdata = 8'h66;
        tick();
        dbg_req = 1'b0; wen = 1'b0;
        chk("dbg_rf_ack", 32'(dbg_ack), 32'h1);
        chk("dbg_rf_old", 32'(dbg_rdata), 32'h55);
        core_read(7'h21);
        chk("dbg_rf_new", 32'(rdata), 32'h66);

        // Reset asserted part-way through a clear pass.
        rst = 1'b1;
        tick();
        chk("rst2_init", 32'(init_done), 32'h0);
        chk("rst2_rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
`ifdef SERV_RF_RAM_RESP_CLEAR_EN
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (127) tick();
        chk("mid_init_127", 32'(init_done), 32'h0);
        tick();
        chk("mid_init_128", 32'(init_done), 32'h1);
        core_read(7'h7F);
        chk("mid_clr_7f", 32'(rdata), 32'h0);
        core_read(7'h05);
        chk("mid_clr_05", 32'(rdata), 32'h0);
`else
        tick();
        chk("rst2_init_1cyc", 32'(init_done), 32'h1);
        core_read(7'h7F);
        chk("rst2_mem_kept", 32'(rdata), 32'h3C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
